// File: rtl/vga_pattern_sequencer_pkg.sv
// Shared types and constants for the VGA pattern sequencer: the SHOW/BLANK
// state encoding, the scroll and pattern index widths, the LFSR constants
// used by the random ordering mode, and small helpers for the next index.
package vga_seq_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } seq_state_t;

    localparam int SCROLL_W  = 10;
    localparam int PATTERN_W = 3;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bit positions 7,5,4,3).
    localparam int                    LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 8'hB8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 8'h01;

    // Sequential pattern order, wrapping from num-1 back to 0.
    function automatic logic [PATTERN_W-1:0] next_pattern(
        input logic [PATTERN_W-1:0] cur,
        input int unsigned          num
    );
        if (cur == PATTERN_W'(num - 1)) begin
            return '0;
        end
        return cur + PATTERN_W'(1);
    endfunction

    // Feedback bit is the XOR of the tapped positions.
    function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/vga_pattern_sequencer_edge_rise_detect.sv
// Registered rising-edge detector. The delayed copy resets to RESET_VAL so
// an input that is already high when reset releases does not look like a
// fresh edge (RESET_VAL = 1) unless the instance asks otherwise.
module edge_rise_detect
    import vga_seq_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    // Keep a one-clock delayed copy of the input level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig_q <= RESET_VAL;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous sequencer for the VGA test-pattern datapath. Chooses the
// active pattern, advances the horizontal scroll once per frame and inserts
// blank frames around every pattern change. All state moves only on a frame
// tick (rising vsync), so the pixel logic never sees a mid-frame change.
// Build option: define SEQ_RANDOM_EN to pick the next pattern from an 8-bit
// LFSR instead of the plain increment order.
module vga_pattern_sequencer
    import vga_seq_pkg::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_FRAMES = 240,
    parameter int BLANK_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic                 auto_en,
    input  logic                 next_req,
    input  logic                 pause,
    input  logic [1:0]           speed,
    output logic [PATTERN_W-1:0] pattern_sel,
    output logic [SCROLL_W-1:0]  scroll,
    output logic                 blank,
    output logic                 frame_tick
);

    localparam int DWELL_W = $clog2(DWELL_FRAMES) + 1;
    localparam int BLANK_W = $clog2(BLANK_FRAMES) + 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_FRAMES - 1);

    logic w_ftick;
    logic w_next_rise;

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [DWELL_W-1:0]   r_dwell_cnt;
    logic [DWELL_W-1:0]   w_dwell_nxt;
    logic [BLANK_W-1:0]   r_blank_cnt;
    logic [BLANK_W-1:0]   w_blank_nxt;
    logic                 r_pending;
    logic                 w_pending_nxt;
    logic                 w_consume;
    logic [PATTERN_W-1:0] r_pattern_sel;
    logic [PATTERN_W-1:0] w_pattern_nxt;
    logic [SCROLL_W-1:0]  r_scroll;
    logic [SCROLL_W-1:0]  w_scroll_nxt;
    logic [PATTERN_W-1:0] w_upcoming_pattern;

    // vsync and next_req both reset their delayed copy high, so a level that
    // is already high out of reset is not mistaken for a new edge.
    edge_rise_detect #(
        .RESET_VAL (1'b1)
    ) u_vsync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (vsync),
        .o_rise (w_ftick)
    );

    edge_rise_detect #(
        .RESET_VAL (1'b1)
    ) u_next_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (next_req),
        .o_rise (w_next_rise)
    );

`ifdef SEQ_RANDOM_EN
    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [PATTERN_W-1:0]  w_rand_idx;

    // Step the pseudo-random sequence once per frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_ftick) begin
            r_lfsr <= {r_lfsr[LFSR_WIDTH-2:0], lfsr_feedback(r_lfsr)};
        end
    end

    // Random index, nudged forward when it would repeat the current pattern.
    always_comb begin
        w_rand_idx         = PATTERN_W'(r_lfsr % LFSR_WIDTH'(NUM_PATTERNS));
        w_upcoming_pattern = w_rand_idx;
        if (w_rand_idx == r_pattern_sel) begin
            w_upcoming_pattern = next_pattern(r_pattern_sel, NUM_PATTERNS);
        end
    end
`else
    // Plain round-robin order.
    always_comb begin
        w_upcoming_pattern = next_pattern(r_pattern_sel, NUM_PATTERNS);
    end
`endif

    // State register for the SHOW/BLANK sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SHOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame-tick decisions: start a blank period, scroll, or finish blanking.
    always_comb begin
        w_state_nxt   = r_state;
        w_dwell_nxt   = r_dwell_cnt;
        w_blank_nxt   = r_blank_cnt;
        w_pattern_nxt = r_pattern_sel;
        w_scroll_nxt  = r_scroll;
        w_consume     = 1'b0;

        if (w_ftick) begin
            case (r_state)
                SHOW: begin
                    if (r_pending || (auto_en && !pause && (r_dwell_cnt == DWELL_LAST))) begin
                        w_state_nxt = BLANK;
                        w_dwell_nxt = '0;
                        w_blank_nxt = '0;
                        w_consume   = 1'b1;
                    end else if (!pause) begin
                        w_scroll_nxt = r_scroll + (SCROLL_W'(1) << speed);
                        w_dwell_nxt  = auto_en ? (r_dwell_cnt + DWELL_W'(1)) : '0;
                    end
                end
                BLANK: begin
                    if (r_blank_cnt == BLANK_LAST) begin
                        w_state_nxt   = SHOW;
                        w_pattern_nxt = w_upcoming_pattern;
                        w_scroll_nxt  = '0;
                        w_blank_nxt   = '0;
                    end else begin
                        w_blank_nxt = r_blank_cnt + BLANK_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = SHOW;
                end
            endcase
        end

        // An edge arriving in the same clock as a consume becomes a new request.
        w_pending_nxt = (r_pending & ~w_consume) | w_next_rise;
    end

    // Counters, pattern index, scroll offset and the sticky request flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dwell_cnt   <= '0;
            r_blank_cnt   <= '0;
            r_pending     <= 1'b0;
            r_pattern_sel <= '0;
            r_scroll      <= '0;
        end else begin
            r_dwell_cnt   <= w_dwell_nxt;
            r_blank_cnt   <= w_blank_nxt;
            r_pending     <= w_pending_nxt;
            r_pattern_sel <= w_pattern_nxt;
            r_scroll      <= w_scroll_nxt;
        end
    end

    assign pattern_sel = r_pattern_sel;
    assign scroll      = r_scroll;
    assign blank       = (r_state == BLANK);
    assign frame_tick  = w_ftick;

endmodule
